// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM read arbiter.
package rom_arb_pkg;

  localparam int ROM_AW_DEF = 8;
  localparam int ROM_DW_DEF = 8;

  // Widest requester id needed for up to 8 requesters.
  localparam int ID_MAX_W = 3;

  // Requester id width: $clog2(n), but never less than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One in-flight read: whether the slot holds a read, and who issued it.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rom_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rom_arb_rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_id,
  output logic            win_any
);

  logic [IDW-1:0] idx;

  // Walk the ring starting at ptr; the first eligible requester wins.
  always_comb begin
    win_oh  = '0;
    win_id  = '0;
    win_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!win_any && elig[idx]) begin
        win_oh[idx] = 1'b1;
        win_id      = idx;
        win_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_rd_arb.sv
// Round-robin read arbiter sharing one single-port ROM among NREQ requesters.
// Grants and ROM strobes are registered; read data returns through a tag
// pipeline that matches the ROM read latency.
module rom_rd_arb
  import rom_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = ROM_AW_DEF,
  parameter int DW     = ROM_DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             rom_ce,
  output logic             rom_ren,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data
);

  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            rom_ce_q, rom_ce_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  tag_t            tag_q [RD_LAT];
  tag_t            tag_d [RD_LAT];

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_id;
  logic            win_any;
  tag_t            head;

  // A requester being granted this cycle is masked so it can update its address.
  assign elig = req & ~gnt_q;

  rom_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .elig    (elig),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_id  (win_id),
    .win_any (win_any)
  );

  // Next grant, ROM strobe/address and round-robin pointer.
  always_comb begin
    gnt_d      = '0;
    gnt_id_d   = win_id;
    rom_ce_d   = win_any;
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    if (win_any) begin
      gnt_d      = win_oh;
      rom_addr_d = req_addr[int'(win_id)*AW +: AW];
      ptr_d      = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  // Tag pipeline: the grant of the ending cycle enters, everything shifts by one.
  always_comb begin
    tag_d[0].valid = |gnt_q;
    tag_d[0].id    = ID_MAX_W'(gnt_id_q);
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Arbiter and tag state registers; reset discards any in-flight reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
      ptr_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
      ptr_q      <= ptr_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign head = tag_q[RD_LAT-1];

  // The head tag lines up with the ROM data; decode it into a one-hot valid.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = head.valid && (head.id == ID_MAX_W'(i));
    end
  end

  assign gnt      = gnt_q;
  assign rom_ce   = rom_ce_q;
  assign rom_ren  = rom_ce_q;
  assign rom_addr = rom_addr_q;
  assign rdata    = rom_data;

endmodule

// File: tb/tb_rom_rd_arb.sv
// Directed bench for rom_rd_arb: a 2-requester/latency-1 instance and a
// 3-requester/latency-3 instance, each with a behavioural ROM.
module tb_rom_rd_arb;

  logic clk;
  logic resetn;

  // NREQ=2, RD_LAT=1 instance
  logic [1:0]  req2;
  logic [15:0] req_addr2;
  logic [1:0]  gnt2, rvalid2;
  logic [7:0]  rdata2, addr2, rom_data2;
  logic        ce2, ren2;

  // NREQ=3, RD_LAT=3 instance
  logic [2:0]  req3;
  logic [23:0] req_addr3;
  logic [2:0]  gnt3, rvalid3;
  logic [7:0]  rdata3, addr3, rom_data3;
  logic        ce3, ren3;

  int n_cmp = 0;
  int n_err = 0;

  rom_rd_arb #(.NREQ(2), .AW(8), .DW(8), .RD_LAT(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .req(req2), .req_addr(req_addr2),
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
    .rom_ce(ce2), .rom_ren(ren2), .rom_addr(addr2), .rom_data(rom_data2)
  );

  rom_rd_arb #(.NREQ(3), .AW(8), .DW(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .req(req3), .req_addr(req_addr3),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
    .rom_ce(ce3), .rom_ren(ren3), .rom_addr(addr3), .rom_data(rom_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents
  function automatic logic [7:0] rom_f(input logic [7:0] a);
    logic [7:0] m;
    m = a * 8'd7;
    return m ^ 8'h5A;
  endfunction

  // Latency-1 ROM
  logic [7:0] rq2;
  always @(posedge clk) if (ce2 && ren2) rq2 <= rom_f(addr2);
  assign rom_data2 = rq2;

  // Latency-3 ROM
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    if (ce3 && ren3) p3[0] <= rom_f(addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rom_data3 = p3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a2(input int i, input logic [7:0] a);
    req_addr2[i*8 +: 8] = a;
  endtask

  task automatic set_a3(input int i, input logic [7:0] a);
    req_addr3[i*8 +: 8] = a;
  endtask

  logic [7:0] a0, a1, a2, prev_a, sa;
  logic [1:0] eg, prev_g;
  logic [2:0] eg3;
  logic [2:0] eg_h [16];
  logic [7:0] ea_h [16];
  int         g0, g1, ce_cnt;

  initial begin
    resetn    = 1'b1;
    req2      = 2'b11;
    req_addr2 = 16'h1110;
    req3      = 3'b000;
    req_addr3 = '0;
    #2 resetn = 1'b0;

    // Reset values with both requesting
    tick();
    chk("rst_gnt", gnt2, 2'b00);
    chk("rst_rvalid", rvalid2, 2'b00);
    chk("rst_ce", ce2, 1'b0);
    chk("rst_ren", ren2, 1'b0);
    chk("rst_addr", addr2, 8'h00);
    tick();
    chk("rst_gnt_hold", gnt2, 2'b00);
    resetn = 1'b1;
    tick();
    chk("rel_gnt", gnt2, 2'b01);
    chk("rel_ce", ce2, 1'b1);
    chk("rel_addr", addr2, 8'h10);
    req2 = 2'b00;
    tick();
    chk("rel_gnt_idle", gnt2, 2'b00);
    chk("rel_rvalid", rvalid2, 2'b01);
    chk("rel_rdata", rdata2, rom_f(8'h10));
    chk("rel_addr_hold", addr2, 8'h10);

    // Single read, requester 0 at 0x05
    set_a2(0, 8'h05);
    req2 = 2'b01;
    tick();
    chk("one_gnt", gnt2, 2'b01);
    chk("one_ce", ce2, 1'b1);
    chk("one_ren", ren2, 1'b1);
    chk("one_addr", addr2, 8'h05);
    req2 = 2'b00;
    tick();
    chk("one_rvalid", rvalid2, 2'b01);
    chk("one_rdata", rdata2, rom_f(8'h05));
    chk("one_ce_off", ce2, 1'b0);

    // Single read, requester 1 at 0x77 (leaves ptr at 0)
    set_a2(1, 8'h77);
    req2 = 2'b10;
    tick();
    chk("one1_gnt", gnt2, 2'b10);
    chk("one1_addr", addr2, 8'h77);
    req2 = 2'b00;
    tick();
    chk("one1_rvalid", rvalid2, 2'b10);
    chk("one1_rdata", rdata2, rom_f(8'h77));

    // Contention: both held for 20 cycles, fresh address after each grant
    a0 = 8'h40; a1 = 8'h80;
    set_a2(0, a0); set_a2(1, a1);
    req2 = 2'b11;
    prev_g = 2'b00; prev_a = 8'h00;
    g0 = 0; g1 = 0; ce_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      eg = (j % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_gnt", gnt2, eg);
      chk("cont_addr", addr2, eg[0] ? a0 : a1);
      chk("cont_rvalid", rvalid2, prev_g);
      if (prev_g != 2'b00) chk("cont_rdata", rdata2, rom_f(prev_a));
      if (gnt2[0]) g0++;
      if (gnt2[1]) g1++;
      if (ce2) ce_cnt++;
      prev_g = eg;
      prev_a = eg[0] ? a0 : a1;
      if (eg[0]) begin a0 = a0 + 8'd1; set_a2(0, a0); end
      else       begin a1 = a1 + 8'd1; set_a2(1, a1); end
    end
    chk("cont_cnt0", g0, 10);
    chk("cont_cnt1", g1, 10);
    chk("cont_ce_cnt", ce_cnt, 20);
    req2 = 2'b00;
    tick();
    chk("cont_tail_gnt", gnt2, 2'b00);
    chk("cont_tail_rvalid", rvalid2, 2'b10);
    chk("cont_tail_rdata", rdata2, rom_f(prev_a));

    // Mid-flight reset: the read of 0x20 must never return
    set_a2(1, 8'h20);
    req2 = 2'b10;
    tick();
    chk("mid_gnt", gnt2, 2'b10);
    chk("mid_addr", addr2, 8'h20);
    resetn = 1'b0;
    req2 = 2'b00;
    #1;
    chk("mid_async_gnt", gnt2, 2'b00);
    chk("mid_async_ce", ce2, 1'b0);
    chk("mid_async_addr", addr2, 8'h00);
    tick();
    chk("mid_rvalid_a", rvalid2, 2'b00);
    tick();
    chk("mid_rvalid_b", rvalid2, 2'b00);
    resetn = 1'b1;
    tick();
    chk("mid_rvalid_c", rvalid2, 2'b00);
    set_a2(0, 8'h30); set_a2(1, 8'h31);
    req2 = 2'b11;
    tick();
    chk("mid_first_gnt", gnt2, 2'b01);
    tick();
    chk("mid_second_gnt", gnt2, 2'b10);
    chk("mid_rvalid_d", rvalid2, 2'b01);
    chk("mid_rdata_d", rdata2, rom_f(8'h30));
    req2 = 2'b00;
    tick();
    chk("mid_rvalid_e", rvalid2, 2'b10);
    chk("mid_rdata_e", rdata2, rom_f(8'h31));

    // Address sweep on requester 0: 0x00..0x27 then 0xFF
    for (int i = 0; i <= 40; i++) begin
      sa = (i == 40) ? 8'hFF : 8'(i);
      set_a2(0, sa);
      req2 = 2'b01;
      tick();
      chk("sw_gnt", gnt2, 2'b01);
      chk("sw_ce", ce2, 1'b1);
      chk("sw_addr", addr2, sa);
      tick();
      chk("sw_ce_off", ce2, 1'b0);
      chk("sw_rvalid", rvalid2, 2'b01);
      chk("sw_rdata", rdata2, rom_f(sa));
    end
    req2 = 2'b00;
    tick();
    chk("sw_idle_rvalid", rvalid2, 2'b00);

    // NREQ=3, RD_LAT=3 with req=101: grants 0,2,0,2...
    a0 = 8'h60; a2 = 8'h62;
    set_a3(0, a0); set_a3(2, a2);
    req3 = 3'b101;
    for (int j = 0; j < 12; j++) begin
      tick();
      eg3 = (j % 2 == 0) ? 3'b001 : 3'b100;
      chk("n3_gnt", gnt3, eg3);
      chk("n3_addr", addr3, eg3[0] ? a0 : a2);
      eg_h[j] = eg3;
      ea_h[j] = eg3[0] ? a0 : a2;
      if (j >= 3) begin
        chk("n3_rvalid", rvalid3, eg_h[j-3]);
        chk("n3_rdata", rdata3, rom_f(ea_h[j-3]));
      end else begin
        chk("n3_rvalid_early", rvalid3, 3'b000);
      end
      if (eg3[0]) begin a0 = a0 + 8'd1; set_a3(0, a0); end
      else        begin a2 = a2 + 8'd1; set_a3(2, a2); end
    end
    req3 = 3'b000;
    for (int j = 12; j < 15; j++) begin
      tick();
      chk("n3_tail_gnt", gnt3, 3'b000);
      chk("n3_tail_rvalid", rvalid3, eg_h[j-3]);
      chk("n3_tail_rdata", rdata3, rom_f(ea_h[j-3]));
    end
    tick();
    chk("n3_done_rvalid", rvalid3, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
